// File: rtl/grb_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// grb_frame_sequencer_if
// Bundles the frame-request, pixel, bit-counter and strip-output signals of
// grb_frame_sequencer.
//   master : game-logic / bench side (drives start, pixel_data, bit_count)
//   slave  : sequencer side (drives clear_counter, inc_counter, dout, busy, done)
// Signals:
//   start          frame request, only honoured while the sequencer is idle
//   pixel_data     packed frame, LED0 in the top 24 bits, each LED G,R,B
//   bit_count      current value of the external 8-bit bit counter
//   clear_counter  holds the bit counter at zero
//   inc_counter    one-cycle increment request for the bit counter
//   dout           serial strip data
//   busy           sequencer not idle
//   done           one-cycle pulse at the end of the latch period
// ---------------------------------------------------------------------------
interface grb_frame_sequencer_if #(
   parameter int NUM_LEDS = 4
) ();
   logic                    start;
   logic [NUM_LEDS*24-1:0]  pixel_data;
   logic [7:0]              bit_count;
   logic                    clear_counter;
   logic                    inc_counter;
   logic                    dout;
   logic                    busy;
   logic                    done;

   modport master (
      output start,
      output pixel_data,
      output bit_count,
      input  clear_counter,
      input  inc_counter,
      input  dout,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  pixel_data,
      input  bit_count,
      output clear_counter,
      output inc_counter,
      output dout,
      output busy,
      output done
   );
endinterface

// File: rtl/grb_frame_sequencer.sv
// ---------------------------------------------------------------------------
// grb_frame_sequencer
// Serialises one WS2812-style GRB frame onto the strip data line. The packed
// pixel buffer is captured on start and shifted out MSB-first; each bit is a
// high pulse (T0H or T1H) followed by low for the rest of the bit period. An
// external 8-bit counter tracks the bit index: it is cleared while idle and
// incremented once per bit, and its value ends the frame. A latch low period
// closes the frame.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    grb_frame_sequencer_if.slave (start, pixel_data, bit_count in;
//          clear_counter, inc_counter, dout, busy, done out)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start, bit counter held clear
// S_HIGH  | dout high for the current bit's high time
// S_LOW   | dout low for the remainder of the bit period
// S_LATCH | dout low for the strip latch/reset period, then done
// ---------------------------------------------------------------------------
module grb_frame_sequencer #(
   parameter int NUM_LEDS   = 4,
   parameter int CLKS_T0H   = 40,
   parameter int CLKS_T1H   = 80,
   parameter int CLKS_BIT   = 125,
   parameter int CLKS_LATCH = 5000
) (
   input  logic                  clk,
   input  logic                  reset,
   grb_frame_sequencer_if.slave  bus
);

   localparam int NBITS = NUM_LEDS * 24;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_HIGH  = 2'd1;
   localparam logic [1:0] S_LOW   = 2'd2;
   localparam logic [1:0] S_LATCH = 2'd3;

   // Terminal values of the 13-bit phase timer (timer counts from 0).
   localparam logic [12:0] T0H_LAST   = 13'(CLKS_T0H - 1);
   localparam logic [12:0] T1H_LAST   = 13'(CLKS_T1H - 1);
   localparam logic [12:0] T0L_LAST   = 13'(CLKS_BIT - CLKS_T0H - 1);
   localparam logic [12:0] T1L_LAST   = 13'(CLKS_BIT - CLKS_T1H - 1);
   localparam logic [12:0] LATCH_LAST = 13'(CLKS_LATCH - 1);
   localparam logic [7:0]  LAST_BIT   = 8'(NBITS - 1);

   logic [1:0]       state_q, state_d;
   logic [12:0]      timer_q, timer_d;
   logic [NBITS-1:0] shift_q, shift_d;

   logic bit_val;
   logic high_end;
   logic low_end;
   logic latch_end;

   // The shift register only moves at the end of LOW, so its MSB is the
   // current bit for both halves of the bit period.
   assign bit_val   = shift_q[NBITS-1];
   assign high_end  = (state_q == S_HIGH)  && (timer_q == (bit_val ? T1H_LAST : T0H_LAST));
   assign low_end   = (state_q == S_LOW)   && (timer_q == (bit_val ? T1L_LAST : T0L_LAST));
   assign latch_end = (state_q == S_LATCH) && (timer_q == LATCH_LAST);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 13'd1;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (bus.start) begin
               shift_d = bus.pixel_data;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (high_end) begin
               state_d = S_LOW;
               timer_d = '0;
            end
         end
         S_LOW: begin
            if (low_end) begin
               shift_d = shift_q << 1;
               timer_d = '0;
               // bit_count still holds the index of the bit just finished;
               // the increment lands on this same edge.
               state_d = (bus.bit_count == LAST_BIT) ? S_LATCH : S_HIGH;
            end
         end
         default: begin
            if (latch_end) begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         shift_q <= shift_d;
      end
   end

   // Outputs are pure decodes of registered state and timer.
   assign bus.dout          = (state_q == S_HIGH);
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.clear_counter = (state_q == S_IDLE);
   assign bus.inc_counter   = low_end;
   assign bus.done          = latch_end;

endmodule

// File: tb/tb_grb_frame_sequencer.sv
module tb_grb_frame_sequencer;

   localparam int NL_A   = 4;
   localparam int NB_A   = NL_A * 24;
   localparam int NL_B   = 1;
   localparam int T0H    = 40;
   localparam int T1H    = 80;
   localparam int TBIT   = 125;
   localparam int TLATCH = 5000;

   logic clk = 1'b0;
   logic reset;
   logic reset_b;

   always #5 clk = ~clk;

   grb_frame_sequencer_if #(.NUM_LEDS(NL_A)) bus_a ();
   grb_frame_sequencer_if #(.NUM_LEDS(NL_B)) bus_b ();

   grb_frame_sequencer #(
      .NUM_LEDS(NL_A), .CLKS_T0H(T0H), .CLKS_T1H(T1H), .CLKS_BIT(TBIT), .CLKS_LATCH(TLATCH)
   ) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   grb_frame_sequencer #(
      .NUM_LEDS(NL_B), .CLKS_T0H(T0H), .CLKS_T1H(T1H), .CLKS_BIT(TBIT), .CLKS_LATCH(TLATCH)
   ) dut_b (
      .clk   (clk),
      .reset (reset_b),
      .bus   (bus_b)
   );

   // External clear/increment bit counters
   logic [7:0] cnt_a, cnt_b;
   always @(posedge clk) begin
      if (bus_a.clear_counter)    cnt_a <= 8'd0;
      else if (bus_a.inc_counter) cnt_a <= cnt_a + 8'd1;
      if (bus_b.clear_counter)    cnt_b <= 8'd0;
      else if (bus_b.inc_counter) cnt_b <= cnt_b + 8'd1;
   end
   assign bus_a.bit_count = cnt_a;
   assign bus_b.bit_count = cnt_b;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string why);
      checks++;
      errors++;
      $display("FAIL %s: %s", name, why);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: expected high time of every bit, and per-frame length/bit count
   int exp_high_q[$];
   int exp_len_q[$];
   int exp_nb_q[$];

   // Reference model: walk LEDs, then G, R, B bytes, each byte MSB first.
   task automatic push_frame(input logic [NB_A-1:0] px);
      logic [23:0] led;
      logic [7:0]  colour;
      for (int l = 0; l < NL_A; l++) begin
         led = px[NB_A-1-24*l -: 24];
         for (int c = 0; c < 3; c++) begin
            colour = led[23-8*c -: 8];
            for (int b = 7; b >= 0; b--) exp_high_q.push_back(colour[b] ? T1H : T0H);
         end
      end
      exp_len_q.push_back(NB_A * TBIT + TLATCH);
      exp_nb_q.push_back(NB_A);
   endtask

   task automatic flush_sb();
      exp_high_q.delete();
      exp_len_q.delete();
      exp_nb_q.delete();
   endtask

   // Monitor for DUT A: measures pulses and frames, pops the scoreboard
   initial begin
      int  cyc, hi_len, lo_len, last_hi, bit_idx, inc_cnt, frame_start, n;
      bit  prev, in_frame, busy_fall;
      cyc = 0; prev = 0; in_frame = 0; busy_fall = 0;
      hi_len = 0; lo_len = 0; last_hi = 0; bit_idx = 0; inc_cnt = 0; frame_start = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            prev = 0; in_frame = 0; busy_fall = 0; hi_len = 0; lo_len = 0;
         end else begin
            if (busy_fall) begin
               chk("busy_after_done", int'(bus_a.busy), 0);
               busy_fall = 0;
            end
            if (bus_a.dout && !prev) begin
               if (!in_frame) begin
                  in_frame = 1; frame_start = cyc; bit_idx = 0; inc_cnt = 0;
               end else begin
                  chk("bit_period", last_hi + lo_len, TBIT);
               end
               chk("bit_count_at_bit_start", int'(bus_a.bit_count), bit_idx);
               chk("busy_in_frame", int'(bus_a.busy), 1);
               hi_len = 1;
            end else if (bus_a.dout) begin
               hi_len++;
            end else if (prev) begin
               if (exp_high_q.size() == 0) fail("high_time", "pulse with no expected bit");
               else chk("high_time", hi_len, exp_high_q.pop_front());
               last_hi = hi_len;
               bit_idx++;
               lo_len = 1;
            end else if (in_frame) begin
               lo_len++;
            end
            if (bus_a.inc_counter) inc_cnt++;
            if (bus_a.done) begin
               if (!in_frame || exp_len_q.size() == 0) begin
                  fail("done", "done pulse with no frame in flight");
               end else begin
                  chk("frame_len", cyc - frame_start + 1, exp_len_q.pop_front());
                  n = exp_nb_q.pop_front();
                  chk("bits_in_frame", bit_idx, n);
                  chk("inc_pulses", inc_cnt, n);
                  chk("latch_low", lo_len, TBIT - last_hi + TLATCH);
               end
               in_frame = 0;
               busy_fall = 1;
            end
            prev = bus_a.dout;
         end
      end
   end

   // DUT B: one LED, all ones
   bit b_finished = 0;
   initial begin
      int  cyc, hi, lo, pulses, fstart;
      bit  prev, in_f;
      cyc = 0; hi = 0; lo = 0; pulses = 0; fstart = 0; prev = 0; in_f = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_b) begin
            if (bus_b.dout && !prev) begin
               if (!in_f) begin
                  in_f = 1; fstart = cyc; pulses = 0;
               end else begin
                  chk("b_low_time", lo, TBIT - T1H);
               end
               hi = 1;
            end else if (bus_b.dout) begin
               hi++;
            end else if (prev) begin
               chk("b_high_time", hi, T1H);
               pulses++;
               lo = 1;
            end else begin
               lo++;
            end
            if (bus_b.done) begin
               chk("b_frame_len", cyc - fstart + 1, 24 * TBIT + TLATCH);
               chk("b_pulses", pulses, 24);
               in_f = 0;
               b_finished = 1;
            end
            prev = bus_b.dout;
         end
      end
   end

   initial begin
      reset_b = 1'b1;
      bus_b.start = 1'b0;
      bus_b.pixel_data = '1;
      repeat (3) tick();
      reset_b = 1'b0;
      tick();
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
   end

   task automatic start_frame(input logic [NB_A-1:0] px, input bit hold);
      bus_a.pixel_data = px;
      push_frame(px);
      bus_a.start = 1'b1;
      tick();
      chk("start_latency_dout", int'(bus_a.dout), 1);
      chk("start_latency_busy", int'(bus_a.busy), 1);
      if (!hold) bus_a.start = 1'b0;
   endtask

   task automatic wait_frame_end(input int budget, input string name);
      int n = 0;
      while ((exp_len_q.size() != 0 || bus_a.busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) fail(name, "frame did not finish within cycle budget");
   endtask

   function automatic logic [NB_A-1:0] rand_px();
      logic [NB_A-1:0] px;
      for (int i = 0; i < NB_A; i += 32) px[i +: 32] = $urandom();
      return px;
   endfunction

   initial begin
      logic [NB_A-1:0] px;
      int n;
      reset = 1'b1;
      bus_a.start = 1'b0;
      bus_a.pixel_data = '0;
      repeat (3) tick();
      chk("reset_dout", int'(bus_a.dout), 0);
      chk("reset_busy", int'(bus_a.busy), 0);
      chk("reset_done", int'(bus_a.done), 0);
      chk("reset_inc", int'(bus_a.inc_counter), 0);
      chk("reset_clear", int'(bus_a.clear_counter), 1);
      reset = 1'b0;
      tick();

      // Abort a frame during bit 10
      start_frame(rand_px(), 0);
      n = 0;
      while (cnt_a != 8'd10 && n < 20 * TBIT) begin tick(); n++; end
      if (n >= 20 * TBIT) fail("reach_bit10", "bit counter never reached 10");
      repeat (5) tick();
      reset = 1'b1;
      flush_sb();
      tick();
      chk("abort_dout", int'(bus_a.dout), 0);
      chk("abort_busy", int'(bus_a.busy), 0);
      chk("abort_inc", int'(bus_a.inc_counter), 0);
      chk("abort_clear", int'(bus_a.clear_counter), 1);
      reset = 1'b0;
      repeat (2) tick();

      // Full random frame; pixel_data changes right after load, and a start
      // pulse mid-frame must be ignored
      px = rand_px();
      start_frame(px, 0);
      bus_a.pixel_data = ~px;
      repeat (300) tick();
      bus_a.pixel_data = rand_px();
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      wait_frame_end(20000, "random_frame");
      repeat (3) tick();

      // start held high: corner pattern, then back-to-back all-zero frame
      start_frame(96'h800000_000000_000000_000001, 1);
      bus_a.pixel_data = '0;
      push_frame('0);
      n = 0;
      while (!bus_a.done && n < 20000) begin tick(); n++; end
      if (n >= 20000) fail("held_first_done", "done never seen");
      tick();
      chk("b2b_gap_busy", int'(bus_a.busy), 0);
      chk("b2b_gap_dout", int'(bus_a.dout), 0);
      tick();
      chk("b2b_restart_dout", int'(bus_a.dout), 1);
      chk("b2b_restart_busy", int'(bus_a.busy), 1);
      bus_a.start = 1'b0;
      wait_frame_end(20000, "held_second_frame");
      repeat (5) tick();
      chk("no_extra_frame", int'(bus_a.busy), 0);

      chk("leftover_bits", exp_high_q.size(), 0);
      chk("leftover_frames", exp_len_q.size(), 0);
      n = 0;
      while (!b_finished && n < 10000) begin tick(); n++; end
      if (!b_finished) fail("b_frame", "single-LED frame never completed");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/grb_frame_sequencer.md
# grb_frame_sequencer

- Sequences one complete WS2812-style GRB frame onto the LED strip data line.
- Latches a packed pixel buffer on `start` and serialises it MSB-first with per-bit high/low pulse timing.
- Drives the external 8-bit bit counter through its clear/increment interface and reads its count back to detect end of frame.
- Finishes each frame with a latch (reset) low period.
- Sits between the game logic, which supplies colours, and the strip output pin.

## Interface

Parameters:
- NUM_LEDS, 4, number of LED modules per frame; legal range 1..10 (NUM_LEDS*24 ≤ 256)
- CLKS_T0H, 40, clk cycles dout is high for a 0 bit (0.40 µs at 100 MHz)
- CLKS_T1H, 80, clk cycles dout is high for a 1 bit (0.80 µs)
- CLKS_BIT, 125, total clk cycles per bit (1.25 µs); must exceed CLKS_T1H
- CLKS_LATCH, 5000, clk cycles of low after the last bit (50 µs)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  frame request; sampled only in IDLE
- pixel_data  in  NUM_LEDS*24  packed frame; LED0 occupies the top 24 bits, each LED ordered G[7:0],R[7:0],B[7:0]
- bit_count  in  8  current value from the bit counter
- clear_counter  out  1  zeroes the bit counter
- inc_counter  out  1  increments the bit counter by one
- dout  out  1  serial strip data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the latch period ends

## Operation

- States:
  - IDLE
  - HIGH: dout=1
  - LOW: dout=0
  - LATCH: dout=0
- Phase timer: 13-bit up-counter, cleared on every state entry.
- IDLE:
  - clear_counter is high whenever state=IDLE. This holds the bit counter at 0 between frames.
  - On start=1: load pixel_data into the shift register, then go to HIGH.
- HIGH:
  - Current bit = shift register MSB.
  - Stay CLKS_T1H cycles if the bit is 1, CLKS_T0H cycles if it is 0, then go to LOW.
- LOW:
  - Stay CLKS_BIT − high-time cycles.
  - On the final LOW cycle, assert inc_counter for exactly 1 cycle and shift the register left by 1.
  - In that same final cycle, if bit_count = NUM_LEDS*24−1, go to LATCH. Otherwise go to HIGH.
- LATCH:
  - Stay CLKS_LATCH cycles.
  - On the final cycle assert done, then return to IDLE.
- start is ignored while busy. pixel_data changes after the load cycle have no effect on the frame in flight.
- The bit counter's count wraps at 8 bits. The parameter limit guarantees it never wraps within a frame.
- Reset at any point:
  - State returns to IDLE and the timer clears.
  - dout, busy, done and inc_counter are 0 from the next cycle.
  - The partial frame is abandoned. The next start sends from bit 0.
- Reset values: dout=0, busy=0, done=0, inc_counter=0, clear_counter=1 (IDLE).

## Timing

- All outputs are decodes of registered state and timer. No combinational path exists from start, bit_count or pixel_data to any output.
- Latency: start sampled high at edge N → dout=1 and busy=1 in cycle N+1.
- Bit periods:
  - Each bit period is exactly CLKS_BIT cycles.
  - High time is exactly CLKS_T0H or CLKS_T1H.
  - Consecutive bits are back-to-back with no gap.
- Frame length: NUM_LEDS*24*CLKS_BIT + CLKS_LATCH cycles from the first HIGH cycle. done is high on the last of these cycles. busy falls on the following cycle.
- A back-to-back frame is possible: start may be high on the first IDLE cycle after done.
- inc_counter pulses exactly NUM_LEDS*24 times per frame, one per bit.

## Test plan

- Connect bit_count to an 8-bit clear/increment counter model in the bench.
- All-zero frame (NUM_LEDS=4, defaults), start pulse:
  - Expect 96 high pulses of 40 cycles at a period of 125.
  - Then 5000 low cycles.
  - done at cycle 17000 after the first HIGH cycle; 96 inc_counter pulses.
- pixel_data = 0x800000_000000_000000_000001:
  - First high pulse is 80 cycles.
  - Bits 2..95 are 40 cycles.
  - Bit 96 is 80 cycles.
- pixel_data all ones with NUM_LEDS=1:
  - 24 pulses, each 80 high / 45 low.
  - done after 24*125+5000 = 8000 cycles.
- start held high through the whole frame:
  - Exactly one frame completes.
  - A second frame begins on the cycle after done returns the block to IDLE.
- Reset asserted during bit 10 of the frame:
  - Next cycle: dout=0, busy=0, clear_counter=1.
  - A subsequent start transmits from bit 0 with bit_count = 0.
- pixel_data changed on the cycle after start:
  - The transmitted bits match the value present on the load cycle.
